// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory port-2 signals shared between the two masters,
// the arbiter and the data memory.
interface mem_port_arbiter_if;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] addr0;
   logic [31:0] addr1;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic [1:0]  size0;
   logic [1:0]  size1;
   logic        sign0;
   logic        sign1;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [31:0] rdata;
   logic        busy;
   logic [31:0] mem_addr2;
   logic [31:0] mem_din2;
   logic [1:0]  mem_size;
   logic        mem_sign;
   logic        mem_write2;
   logic        mem_read2;
   logic [31:0] mem_dout2;

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, size0, size1, sign0, sign1, mem_dout2,
      input  gnt, rvalid, rdata, busy, mem_addr2, mem_din2, mem_size, mem_sign, mem_write2, mem_read2
   );

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, size0, size1, sign0, sign1, mem_dout2,
      output gnt, rvalid, rdata, busy, mem_addr2, mem_din2, mem_size, mem_sign, mem_write2, mem_read2
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the OTTER data-memory port 2: MCU has fixed priority,
// the DMA/debug master wins after MAX_WAIT consecutive denied cycles.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate and latch the winner's fields
// ISSUE   | strobe memory with the latched fields, pulse GNT[owner]
// RD_WAIT | strobes low, count read latency, capture MEM_DOUT2 and pulse RVALID
module mem_port_arbiter #(
   parameter int RD_LATENCY = 1,
   parameter int MAX_WAIT   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
   localparam logic [2:0] RD_LAT_C   = 3'(RD_LATENCY);

   state_t     state;
   logic       owner;
   logic       we_lat;
   logic [2:0] lat_cnt;
   logic [7:0] starve_cnt;

   logic       arb;
   logic       win;
   logic       we_sel;
   logic [7:0] starve_nxt;

   always_comb begin
      arb    = (state == IDLE) && (bus.req != 2'b00);
      win    = 1'b0;
      if (bus.req == 2'b10) begin
         win = 1'b1;
      end else if (bus.req == 2'b11) begin
         win = (starve_cnt == MAX_WAIT_C);
      end
      we_sel = win ? bus.we[1] : bus.we[0];

      // Counts every cycle the DMA is requesting but not picked, not just arbitration cycles.
      starve_nxt = starve_cnt;
      if (!bus.req[1] || (arb && win)) begin
         starve_nxt = '0;
      end else if (starve_cnt < MAX_WAIT_C) begin
         starve_nxt = starve_cnt + 8'd1;
      end
   end

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         owner          <= 1'b0;
         we_lat         <= 1'b0;
         lat_cnt        <= '0;
         starve_cnt     <= '0;
         bus.gnt        <= '0;
         bus.rvalid     <= '0;
         bus.rdata      <= '0;
         bus.mem_addr2  <= '0;
         bus.mem_din2   <= '0;
         bus.mem_size   <= '0;
         bus.mem_sign   <= 1'b0;
         bus.mem_write2 <= 1'b0;
         bus.mem_read2  <= 1'b0;
      end else begin
         starve_cnt     <= starve_nxt;
         bus.gnt        <= '0;
         bus.rvalid     <= '0;
         bus.mem_write2 <= 1'b0;
         bus.mem_read2  <= 1'b0;
         case (state)
            IDLE: begin
               if (arb) begin
                  owner          <= win;
                  we_lat         <= we_sel;
                  bus.mem_addr2  <= win ? bus.addr1  : bus.addr0;
                  bus.mem_din2   <= win ? bus.wdata1 : bus.wdata0;
                  bus.mem_size   <= win ? bus.size1  : bus.size0;
                  bus.mem_sign   <= win ? bus.sign1  : bus.sign0;
                  bus.mem_write2 <= we_sel;
                  bus.mem_read2  <= !we_sel;
                  bus.gnt        <= win ? 2'b10 : 2'b01;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               if (we_lat) begin
                  state <= IDLE;
               end else begin
                  lat_cnt <= 3'd1;
                  state   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (lat_cnt == RD_LAT_C) begin
                  bus.rdata  <= bus.mem_dout2;
                  bus.rvalid <= owner ? 2'b10 : 2'b01;
                  state      <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a cycle-indexed transaction model of the arbitration rules.
module tb_mem_port_arbiter;
   localparam int RD_LAT = 1;
   localparam int MAX_W  = 8;
   localparam int RN     = 600;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.RD_LATENCY(RD_LAT), .MAX_WAIT(MAX_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory: read data is valid only exactly RD_LAT cycles after the strobe cycle.
   int          rd_age;
   logic [31:0] rd_addr;
   logic        fixed_en   = 1'b0;
   logic [31:0] fixed_data = '0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_age  <= 0;
         rd_addr <= '0;
      end else if (bus.mem_read2) begin
         rd_age  <= 1;
         rd_addr <= bus.mem_addr2;
      end else if (rd_age > 0 && rd_age < 16) begin
         rd_age  <= rd_age + 1;
      end
   end

   assign bus.mem_dout2 = (rd_age == RD_LAT) ? (fixed_en ? fixed_data : mem_fn(rd_addr)) : 32'h0BAD_0BAD;

   // Expectations indexed by cycle for the randomized run.
   logic [1:0]  exp_gnt   [0:RN+7];
   logic [1:0]  exp_rv    [0:RN+7];
   logic [31:0] exp_rdata [0:RN+7];
   logic        exp_wr    [0:RN+7];
   logic        exp_rd    [0:RN+7];
   logic [31:0] exp_addr  [0:RN+7];
   logic [31:0] exp_din   [0:RN+7];
   logic [1:0]  exp_size  [0:RN+7];
   logic        exp_sign  [0:RN+7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req    = 2'b00;
      bus.we     = 2'b00;
      bus.addr0  = '0;
      bus.addr1  = '0;
      bus.wdata0 = '0;
      bus.wdata1 = '0;
      bus.size0  = 2'b00;
      bus.size1  = 2'b00;
      bus.sign0  = 1'b0;
      bus.sign1  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", bus.gnt); end
      checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", bus.rvalid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
      checks++; if ({bus.mem_write2, bus.mem_read2} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {bus.mem_write2, bus.mem_read2}); end
      checks++; if (bus.mem_addr2 !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.mem_addr2); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
      #2 rst_n = 1'b1;
      // reset asserted while the read is being issued
      tick();
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'h0000_0100;
      tick();
      checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rst_pre_gnt got %b exp 01", bus.gnt); end
      checks++; if (bus.mem_read2 !== 1'b1) begin errors++; $display("FAIL rst_pre_read got %b exp 1", bus.mem_read2); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rst_issue_gnt got %b exp 00", bus.gnt); end
      checks++; if (bus.mem_read2 !== 1'b0) begin errors++; $display("FAIL rst_issue_read got %b exp 0", bus.mem_read2); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_issue_busy got %b exp 0", bus.busy); end
      idle_inputs();
      #1 rst_n = 1'b1;
      // reset asserted in the read wait
      tick();
      bus.req = 2'b01; bus.addr0 = 32'h0000_0200;
      tick();
      bus.req = 2'b00;
      tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy got %b exp 1", bus.busy); end
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.gnt, bus.rvalid, bus.mem_read2, bus.busy} !== 6'b0) begin errors++; $display("FAIL rst_wait_outs got %b exp 000000", {bus.gnt, bus.rvalid, bus.mem_read2, bus.busy}); end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({bus.rvalid, bus.busy} !== 3'b000) begin errors++; $display("FAIL rst_after got rvalid %b busy %b exp 00 0", bus.rvalid, bus.busy); end
      end
   endtask

   task automatic test_single_write();
      bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 32'h0000_6000; bus.wdata0 = 32'hDEAD_BEEF;
      bus.size0 = 2'b10; bus.sign0 = 1'b0;
      tick();
      checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b exp 01", bus.gnt); end
      checks++; if ({bus.mem_write2, bus.mem_read2} !== 2'b10) begin errors++; $display("FAIL wr_strobes got %b exp 10", {bus.mem_write2, bus.mem_read2}); end
      checks++; if (bus.mem_addr2 !== 32'h0000_6000) begin errors++; $display("FAIL wr_addr got %h exp 00006000", bus.mem_addr2); end
      checks++; if (bus.mem_din2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_din got %h exp deadbeef", bus.mem_din2); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", bus.busy); end
      bus.req = 2'b00;
      tick();
      checks++; if ({bus.gnt, bus.mem_write2, bus.busy} !== 4'b0) begin errors++; $display("FAIL wr_after got %b exp 0000", {bus.gnt, bus.mem_write2, bus.busy}); end
   endtask

   task automatic test_read();
      fixed_en = 1'b1; fixed_data = 32'h1234_5678;
      bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 32'h0000_8000; bus.size1 = 2'b10;
      tick();
      checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt got %b exp 10", bus.gnt); end
      checks++; if (bus.mem_read2 !== 1'b1) begin errors++; $display("FAIL rd_strobe got %b exp 1", bus.mem_read2); end
      bus.req = 2'b00;
      tick();
      checks++; if ({bus.gnt, bus.rvalid} !== 4'b0) begin errors++; $display("FAIL rd_wait got gnt %b rvalid %b exp 00 00", bus.gnt, bus.rvalid); end
      tick();
      checks++; if (bus.rvalid !== 2'b10) begin errors++; $display("FAIL rd_rvalid got %b exp 10", bus.rvalid); end
      checks++; if (bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata got %h exp 12345678", bus.rdata); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_busy got %b exp 0", bus.busy); end
      tick();
      checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL rd_rvalid_pulse got %b exp 00", bus.rvalid); end
      fixed_en = 1'b0;
   endtask

   // Both held: MCU writes every 2 cycles; DMA has been denied 8 cycles by the 5th arbitration.
   task automatic test_contention();
      logic [1:0] exp;
      bus.req = 2'b11; bus.we = 2'b11; bus.addr0 = 32'h0000_00A0; bus.addr1 = 32'h0000_00B1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp = (k % 2 == 0) ? 2'b00 : ((k == 9) ? 2'b10 : 2'b01);
         checks++; if (bus.gnt !== exp) begin errors++; $display("FAIL cont_gnt cycle %0d got %b exp %b", k, bus.gnt, exp); end
      end
      bus.req = 2'b00;
      tick();
      tick();
   endtask

   task automatic test_size_sign();
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'h0000_0044; bus.size0 = 2'b00; bus.sign0 = 1'b1;
      tick();
      checks++; if ({bus.mem_size, bus.mem_sign} !== 3'b001) begin errors++; $display("FAIL ss_issue got size %b sign %b exp 00 1", bus.mem_size, bus.mem_sign); end
      bus.req = 2'b00; bus.size0 = 2'b10; bus.sign0 = 1'b0; bus.addr0 = 32'h0000_0F00;
      tick();
      checks++; if ({bus.mem_size, bus.mem_sign, bus.mem_read2} !== 4'b0010) begin errors++; $display("FAIL ss_hold got size %b sign %b read %b exp 00 1 0", bus.mem_size, bus.mem_sign, bus.mem_read2); end
      checks++; if (bus.mem_addr2 !== 32'h0000_0044) begin errors++; $display("FAIL ss_addr_hold got %h exp 00000044", bus.mem_addr2); end
      tick();
      checks++; if (bus.rvalid !== 2'b01) begin errors++; $display("FAIL ss_rvalid got %b exp 01", bus.rvalid); end
      checks++; if (bus.rdata !== mem_fn(32'h0000_0044)) begin errors++; $display("FAIL ss_rdata got %h exp %h", bus.rdata, mem_fn(32'h0000_0044)); end
      bus.req = 2'b10; bus.we = 2'b10; bus.size1 = 2'b01; bus.sign1 = 1'b0; bus.addr1 = 32'h0000_0052;
      tick();
      checks++; if ({bus.gnt, bus.mem_size, bus.mem_sign, bus.mem_write2} !== 6'b10_01_0_1) begin errors++; $display("FAIL ss_dma got gnt %b size %b sign %b wr %b exp 10 01 0 1", bus.gnt, bus.mem_size, bus.mem_sign, bus.mem_write2); end
      bus.req = 2'b00;
      tick();
   endtask

   task automatic test_back_to_back();
      int n = 0;
      logic exp_g;
      bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 32'h0000_1000; bus.wdata0 = 32'h0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_g = (k % 2 == 1);
         checks++; if (bus.gnt !== {1'b0, exp_g}) begin errors++; $display("FAIL b2b_gnt cycle %0d got %b exp %b", k, bus.gnt, {1'b0, exp_g}); end
         checks++; if ({bus.mem_write2, bus.mem_read2} !== {exp_g, 1'b0}) begin errors++; $display("FAIL b2b_strobes cycle %0d got %b exp %b", k, {bus.mem_write2, bus.mem_read2}, {exp_g, 1'b0}); end
         if (exp_g) begin
            checks++; if ({bus.mem_addr2, bus.mem_din2} !== {32'h0000_1000 + 32'(4 * n), 32'h1111_1111 * 32'(n)}) begin errors++; $display("FAIL b2b_data beat %0d got %h/%h exp %h/%h", n, bus.mem_addr2, bus.mem_din2, 32'h0000_1000 + 32'(4 * n), 32'h1111_1111 * 32'(n)); end
            n++;
            bus.addr0  = 32'h0000_1000 + 32'(4 * n);
            bus.wdata0 = 32'h1111_1111 * 32'(n);
         end
      end
      bus.req = 2'b00;
      tick();
   endtask

   task automatic test_random();
      logic        pend   [2];
      logic        a_we   [2];
      logic [31:0] a_addr [2];
      logic [31:0] a_wd   [2];
      logic [1:0]  a_size [2];
      logic        a_sign [2];
      int          free_at = 0;
      int          run     = 0;
      logic        arb;
      int          w;
      for (int i = 0; i < RN + 8; i++) begin
         exp_gnt[i] = '0; exp_rv[i] = '0; exp_rdata[i] = '0; exp_wr[i] = 1'b0; exp_rd[i] = 1'b0;
         exp_addr[i] = '0; exp_din[i] = '0; exp_size[i] = '0; exp_sign[i] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wd[i] = '0; a_size[i] = '0; a_sign[i] = 1'b0;
      end
      for (int c = 0; c < RN; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (exp_gnt[c][i]) pend[i] = 1'b0;
            if (!pend[i] && c < RN - 40 && $urandom_range(0, 7) < ((i == 0) ? 7 : 4)) begin
               pend[i]   = 1'b1;
               a_we[i]   = 1'($urandom_range(0, 1));
               a_addr[i] = $urandom;
               a_wd[i]   = $urandom;
               a_size[i] = 2'($urandom_range(0, 2));
               a_sign[i] = 1'($urandom_range(0, 1));
            end
         end
         bus.req = {pend[1], pend[0]};
         bus.we = {a_we[1], a_we[0]};
         bus.addr0 = a_addr[0]; bus.addr1 = a_addr[1];
         bus.wdata0 = a_wd[0]; bus.wdata1 = a_wd[1];
         bus.size0 = a_size[0]; bus.size1 = a_size[1];
         bus.sign0 = a_sign[0]; bus.sign1 = a_sign[1];

         arb = (c >= free_at) && (pend[0] || pend[1]);
         w = (pend[1] && (!pend[0] || run == MAX_W)) ? 1 : 0;
         if (arb) begin
            exp_gnt[c + 1]  = (w == 1) ? 2'b10 : 2'b01;
            exp_wr[c + 1]   = a_we[w];
            exp_rd[c + 1]   = !a_we[w];
            exp_addr[c + 1] = a_addr[w];
            exp_din[c + 1]  = a_wd[w];
            exp_size[c + 1] = a_size[w];
            exp_sign[c + 1] = a_sign[w];
            if (a_we[w]) begin
               free_at = c + 2;
            end else begin
               free_at = c + RD_LAT + 2;
               exp_rv[c + RD_LAT + 2]    = (w == 1) ? 2'b10 : 2'b01;
               exp_rdata[c + RD_LAT + 2] = mem_fn(a_addr[w]);
            end
         end
         if (!pend[1] || (arb && w == 1)) run = 0;
         else if (run < MAX_W) run++;

         tick();
         checks++; if (bus.gnt !== exp_gnt[c + 1]) begin errors++; $display("FAIL rnd_gnt cycle %0d got %b exp %b", c + 1, bus.gnt, exp_gnt[c + 1]); end
         checks++; if (bus.rvalid !== exp_rv[c + 1]) begin errors++; $display("FAIL rnd_rvalid cycle %0d got %b exp %b", c + 1, bus.rvalid, exp_rv[c + 1]); end
         checks++; if ({bus.mem_write2, bus.mem_read2} !== {exp_wr[c + 1], exp_rd[c + 1]}) begin errors++; $display("FAIL rnd_strobes cycle %0d got %b exp %b", c + 1, {bus.mem_write2, bus.mem_read2}, {exp_wr[c + 1], exp_rd[c + 1]}); end
         checks++; if (bus.busy !== ((c + 1) < free_at)) begin errors++; $display("FAIL rnd_busy cycle %0d got %b exp %b", c + 1, bus.busy, ((c + 1) < free_at)); end
         if (exp_rv[c + 1] != 2'b00) begin
            checks++; if (bus.rdata !== exp_rdata[c + 1]) begin errors++; $display("FAIL rnd_rdata cycle %0d got %h exp %h", c + 1, bus.rdata, exp_rdata[c + 1]); end
         end
         if (exp_wr[c + 1] || exp_rd[c + 1]) begin
            checks++; if ({bus.mem_addr2, bus.mem_size, bus.mem_sign} !== {exp_addr[c + 1], exp_size[c + 1], exp_sign[c + 1]}) begin errors++; $display("FAIL rnd_fields cycle %0d got %h/%b/%b exp %h/%b/%b", c + 1, bus.mem_addr2, bus.mem_size, bus.mem_sign, exp_addr[c + 1], exp_size[c + 1], exp_sign[c + 1]); end
         end
         if (exp_wr[c + 1]) begin
            checks++; if (bus.mem_din2 !== exp_din[c + 1]) begin errors++; $display("FAIL rnd_din cycle %0d got %h exp %h", c + 1, bus.mem_din2, exp_din[c + 1]); end
         end
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_contention();
      test_size_sign();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
